// File: rtl/cond_flag_unit.sv
// cond_flag_unit
//
// Holds the ARM N/Z/C/V status flags for the datapath. It also keeps a
// one-entry shadow copy of the flags for save/restore, and answers 4-bit
// condition-field queries through a request/acknowledge handshake.
//
// Parameter
//   FORWARD      1: a query in the same cycle as a flag write/restore sees
//                   the new flags.
//                0: such a query stalls one extra cycle (HOLD).
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous, active-low reset
//   flag_we      write ALU flags this cycle
//   flag_mask    {N,Z,C,V} per-flag write enable
//   alu_nf/zf/cf/vf  ALU flag outputs
//   save_req     copy the registered flags into the shadow
//   restore_req  copy the shadow into the flags; wins over flag_we
//   cond_req     condition request; a level, held until cond_ack
//   cond         ARM condition field
//   cond_ack     one-cycle acknowledge pulse
//   cond_pass    evaluation result; held until the next ack
//   flags        registered {N,Z,C,V}
//   shadow       registered shadow {N,Z,C,V}
//   cin_out      registered C flag, fed back to the ALU carry-in

module cond_flag_unit #(
    parameter bit FORWARD = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flag_we,
    input  logic [3:0] flag_mask,
    input  logic       alu_nf,
    input  logic       alu_zf,
    input  logic       alu_cf,
    input  logic       alu_vf,
    input  logic       save_req,
    input  logic       restore_req,
    input  logic       cond_req,
    input  logic [3:0] cond,
    output logic       cond_ack,
    output logic       cond_pass,
    output logic [3:0] flags,
    output logic [3:0] shadow,
    output logic       cin_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        ACK  = 2'd2
    } state_t;

    state_t     state_q;
    logic [3:0] flags_q;
    logic [3:0] flags_d;
    logic [3:0] shadow_q;
    logic [3:0] shadow_d;
    logic [3:0] cond_q;
    logic       ack_q;
    logic       pass_q;
    logic [3:0] alu_flags;
    logic [3:0] eval_flags;
    logic       update;
    logic       hazard;

    // ARM condition table, evaluated on flags packed as {N,Z,C,V}.
    function automatic logic cond_eval(input logic [3:0] c, input logic [3:0] f);
        logic n;
        logic z;
        logic cf;
        logic v;
        logic r;
        n  = f[3];
        z  = f[2];
        cf = f[1];
        v  = f[0];
        case (c)
            4'b0000: r = z;
            4'b0001: r = !z;
            4'b0010: r = cf;
            4'b0011: r = !cf;
            4'b0100: r = n;
            4'b0101: r = !n;
            4'b0110: r = v;
            4'b0111: r = !v;
            4'b1000: r = cf & !z;
            4'b1001: r = !cf | z;
            4'b1010: r = (n == v);
            4'b1011: r = (n != v);
            4'b1100: r = !z & (n == v);
            4'b1101: r = z | (n != v);
            4'b1110: r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    assign alu_flags = {alu_nf, alu_zf, alu_cf, alu_vf};
    assign update    = flag_we | restore_req;

    // Restore has priority over an ALU write. The shadow always samples
    // the pre-edge flags, so save and restore in the same cycle swap them.
    always_comb begin
        flags_d  = flags_q;
        shadow_d = shadow_q;
        if (restore_req) begin
            flags_d = shadow_q;
        end else if (flag_we) begin
            flags_d = (flags_q & ~flag_mask) | (alu_flags & flag_mask);
        end
        if (save_req) begin
            shadow_d = flags_q;
        end
    end

    // With forwarding, flags_d already equals flags_q when nothing updates,
    // so the next-state flags can always be used. Without forwarding, an
    // update in the request cycle forces a one-cycle stall instead.
    assign eval_flags = FORWARD ? flags_d : flags_q;
    assign hazard     = !FORWARD && update;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q  <= 4'b0000;
            shadow_q <= 4'b0000;
        end else begin
            flags_q  <= flags_d;
            shadow_q <= shadow_d;
        end
    end

    // Handshake FSM. The condition field is latched at accept, so a
    // stalled request still finishes correctly if cond_req drops during HOLD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ack_q   <= 1'b0;
            pass_q  <= 1'b0;
            cond_q  <= 4'b0000;
        end else begin
            case (state_q)
                IDLE: begin
                    ack_q <= 1'b0;
                    if (cond_req) begin
                        cond_q <= cond;
                        if (hazard) begin
                            state_q <= HOLD;
                        end else begin
                            pass_q  <= cond_eval(cond, eval_flags);
                            ack_q   <= 1'b1;
                            state_q <= ACK;
                        end
                    end
                end
                HOLD: begin
                    pass_q  <= cond_eval(cond_q, flags_q);
                    ack_q   <= 1'b1;
                    state_q <= ACK;
                end
                ACK: begin
                    ack_q   <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    ack_q   <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign flags     = flags_q;
    assign shadow    = shadow_q;
    assign cin_out   = flags_q[1];
    assign cond_ack  = ack_q;
    assign cond_pass = pass_q;

endmodule

// File: tb/tb_cond_flag_unit.sv
// tb_cond_flag_unit
//
// Drives two copies of cond_flag_unit, one built with FORWARD=1 and one
// with FORWARD=0. Both copies share the flag inputs and the condition
// field, and each has its own cond_req. A behavioural model of the flags,
// the shadow and the ARM condition rules predicts every output.

module tb_cond_flag_unit;

    logic       clk;
    logic       rst_n;
    logic       flag_we;
    logic [3:0] flag_mask;
    logic       alu_nf;
    logic       alu_zf;
    logic       alu_cf;
    logic       alu_vf;
    logic       save_req;
    logic       restore_req;
    logic       req1;
    logic       req0;
    logic [3:0] cond;

    logic       ack1;
    logic       pass1;
    logic       cin1;
    logic [3:0] flags1;
    logic [3:0] shadow1;
    logic       ack0;
    logic       pass0;
    logic       cin0;
    logic [3:0] flags0;
    logic [3:0] shadow0;

    int checkCount;
    int passCount;

    logic [3:0] modelFlags;
    logic [3:0] modelShadow;
    logic       expPass1;
    logic       expPass0;

    cond_flag_unit #(.FORWARD(1'b1)) dutFwd (
        .clk(clk), .rst_n(rst_n), .flag_we(flag_we), .flag_mask(flag_mask),
        .alu_nf(alu_nf), .alu_zf(alu_zf), .alu_cf(alu_cf), .alu_vf(alu_vf),
        .save_req(save_req), .restore_req(restore_req),
        .cond_req(req1), .cond(cond),
        .cond_ack(ack1), .cond_pass(pass1),
        .flags(flags1), .shadow(shadow1), .cin_out(cin1)
    );

    cond_flag_unit #(.FORWARD(1'b0)) dutStall (
        .clk(clk), .rst_n(rst_n), .flag_we(flag_we), .flag_mask(flag_mask),
        .alu_nf(alu_nf), .alu_zf(alu_zf), .alu_cf(alu_cf), .alu_vf(alu_vf),
        .save_req(save_req), .restore_req(restore_req),
        .cond_req(req0), .cond(cond),
        .cond_ack(ack0), .cond_pass(pass0),
        .flags(flags0), .shadow(shadow0), .cin_out(cin0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference condition rule in ARM form. Bits [3:1] pick a base test and
    // bit 0 inverts it. Code 1110 is always true and code 1111 never passes.
    function automatic logic condTruth(input logic [3:0] c, input logic [3:0] f);
        logic n;
        logic z;
        logic cy;
        logic v;
        logic r;
        n  = f[3];
        z  = f[2];
        cy = f[1];
        v  = f[0];
        case (c[3:1])
            3'd0:    r = z;
            3'd1:    r = cy;
            3'd2:    r = n;
            3'd3:    r = v;
            3'd4:    r = cy && !z;
            3'd5:    r = (n == v);
            3'd6:    r = !z && (n == v);
            default: r = 1'b1;
        endcase
        if (c[3:1] != 3'd7 && c[0]) r = !r;
        if (c == 4'hF) r = 1'b0;
        return r;
    endfunction

    // Count one comparison and report it if it does not match.
    task automatic checkOutput(input string tag, input logic [3:0] actual,
                               input logic [3:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    task automatic checkFlags(input string tag);
        checkOutput({tag, " flags fwd"}, flags1, modelFlags);
        checkOutput({tag, " flags stall"}, flags0, modelFlags);
        checkOutput({tag, " shadow fwd"}, shadow1, modelShadow);
        checkOutput({tag, " shadow stall"}, shadow0, modelShadow);
        checkOutput({tag, " cin fwd"}, {3'b000, cin1}, {3'b000, modelFlags[1]});
        checkOutput({tag, " cin stall"}, {3'b000, cin0}, {3'b000, modelFlags[1]});
    endtask

    task automatic checkCond(input string tag, input logic eAck1, input logic eAck0);
        checkOutput({tag, " ack fwd"}, {3'b000, ack1}, {3'b000, eAck1});
        checkOutput({tag, " pass fwd"}, {3'b000, pass1}, {3'b000, expPass1});
        checkOutput({tag, " ack stall"}, {3'b000, ack0}, {3'b000, eAck0});
        checkOutput({tag, " pass stall"}, {3'b000, pass0}, {3'b000, expPass0});
    endtask

    // Drive one cycle of inputs, clock it in, and advance the flag/shadow
    // model. Outputs are sampled 1 time unit after the rising edge.
    task automatic applyStimulus(input logic we, input logic [3:0] mask,
                                 input logic [3:0] alu, input logic sv,
                                 input logic rs, input logic r1,
                                 input logic r0, input logic [3:0] c);
        logic [3:0] oldFlags;
        flag_we     = we;
        flag_mask   = mask;
        {alu_nf, alu_zf, alu_cf, alu_vf} = alu;
        save_req    = sv;
        restore_req = rs;
        req1        = r1;
        req0        = r0;
        cond        = c;
        @(posedge clk);
        #1;
        oldFlags = modelFlags;
        if (rs) begin
            modelFlags = modelShadow;
        end else if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (mask[b]) modelFlags[b] = alu[b];
            end
        end
        if (sv) modelShadow = oldFlags;
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, cond);
    endtask

    // Issue a query on both units in the same cycle as the given flag
    // activity, then follow both handshakes until they finish.
    task automatic queryWithUpdate(input string tag, input logic we,
                                   input logic [3:0] mask, input logic [3:0] alu,
                                   input logic sv, input logic rs,
                                   input logic [3:0] c);
        logic stall;
        stall = we | rs;
        applyStimulus(we, mask, alu, sv, rs, 1'b1, 1'b1, c);
        checkFlags(tag);
        expPass1 = condTruth(c, modelFlags);
        if (!stall) expPass0 = condTruth(c, modelFlags);
        checkCond({tag, " c1"}, 1'b1, !stall);
        applyStimulus(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, stall, c);
        if (stall) expPass0 = condTruth(c, modelFlags);
        checkCond({tag, " c2"}, 1'b0, stall);
        idleCycle();
        checkCond({tag, " c3"}, 1'b0, 1'b0);
    endtask

    initial begin
        checkCount  = 0;
        passCount   = 0;
        modelFlags  = 4'h0;
        modelShadow = 4'h0;
        expPass1    = 1'b0;
        expPass0    = 1'b0;
        rst_n       = 1'b0;
        flag_we     = 1'b0;
        flag_mask   = 4'h0;
        {alu_nf, alu_zf, alu_cf, alu_vf} = 4'h0;
        save_req    = 1'b0;
        restore_req = 1'b0;
        req1        = 1'b0;
        req0        = 1'b0;
        cond        = 4'h0;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        checkFlags("reset");
        checkCond("reset", 1'b0, 1'b0);
        rst_n = 1'b1;

        // Masked writes.
        applyStimulus(1'b1, 4'b1100, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
        checkOutput("mask1100 flags", flags1, 4'b1100);
        checkFlags("mask1100");
        applyStimulus(1'b1, 4'b0011, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
        checkOutput("mask0011 flags", flags1, 4'b1111);
        checkFlags("mask0011");

        // Full decode sweep: every flag value against every condition code.
        for (int f = 0; f < 16; f++) begin
            for (int c = 0; c < 16; c++) begin
                applyStimulus(1'b1, 4'hF, 4'(f), 1'b0, 1'b0, 1'b0, 1'b0, 4'(c));
                applyStimulus(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 4'(c));
                expPass1 = condTruth(4'(c), modelFlags);
                expPass0 = expPass1;
                checkCond("sweep", 1'b1, 1'b1);
                idleCycle();
                checkCond("sweep hold", 1'b0, 1'b0);
            end
        end
        checkFlags("after sweep");

        // Forwarding: Z written in the same cycle as an EQ query.
        applyStimulus(1'b1, 4'hF, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
        queryWithUpdate("fwd EQ", 1'b1, 4'b0100, 4'b0100, 1'b0, 1'b0, 4'b0000);
        checkOutput("fwd EQ pass", {3'b000, pass0}, 4'h1);

        // Save/restore, restore beating a concurrent write, then a swap.
        applyStimulus(1'b1, 4'hF, 4'b1010, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
        applyStimulus(1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
        checkOutput("save shadow", shadow1, 4'b1010);
        applyStimulus(1'b1, 4'hF, 4'b0101, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
        checkFlags("write 0101");
        applyStimulus(1'b1, 4'hF, 4'b1111, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
        checkOutput("restore flags", flags0, 4'b1010);
        checkFlags("restore");
        applyStimulus(1'b1, 4'hF, 4'b0110, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
        applyStimulus(1'b0, 4'h0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0);
        checkOutput("swap flags", flags1, 4'b1010);
        checkOutput("swap shadow", shadow1, 4'b0110);
        checkFlags("swap");

        // Randomised flag activity with queries in the same cycle.
        for (int i = 0; i < 80; i++) begin
            queryWithUpdate("rand", 1'($urandom_range(0, 1)), 4'($urandom),
                            4'($urandom), 1'($urandom_range(0, 1)),
                            1'($urandom_range(0, 3) == 0), 4'($urandom));
            checkFlags("rand");
        end

        // Reset asserted while the stalling unit sits in HOLD.
        applyStimulus(1'b1, 4'hF, 4'b1011, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0);
        #2;
        rst_n = 1'b0;
        #1;
        modelFlags  = 4'h0;
        modelShadow = 4'h0;
        expPass1    = 1'b0;
        expPass0    = 1'b0;
        checkFlags("rst in hold");
        checkCond("rst in hold", 1'b0, 1'b0);
        applyStimulus(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
        checkCond("rst held", 1'b0, 1'b0);
        rst_n = 1'b1;
        idleCycle();
        checkCond("rst released", 1'b0, 1'b0);
        applyStimulus(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b1110);
        expPass0 = 1'b1;
        checkCond("post rst AL", 1'b0, 1'b1);
        idleCycle();
        checkCond("post rst AL end", 1'b0, 1'b0);

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
